// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for the memory bus arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mem_arb_pkg;

  // Arbiter FSM encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  // Instruction fetches always read a full word.
  localparam logic [3:0] FETCH_BE = 4'b1111;

  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_MAXD    = 4;

  // Watchdog counter width and starvation counter width.
  localparam int WD_W     = 8;
  localparam int STARVE_W = 3;

endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: 8-bit cycle counter that flags when an access has run LIMIT cycles.
// Latency: expired is combinational from the count, asserted during the LIMIT-th enabled cycle.
// Backpressure: none; clear wins over enable, count saturates at all-ones.
module bus_watchdog
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iClr,
  input  logic iEn,
  output logic oExpired
);

  // Count value seen during the LIMIT-th enabled cycle after a clear.
  localparam logic [WD_W-1:0] LAST = 8'(LIMIT - 1);

  logic [WD_W-1:0] count_q;
  logic [WD_W-1:0] count_d;

  // Clear restarts the window; otherwise count enabled cycles without wrapping.
  always_comb begin
    count_d = count_q;
    if (iClr) begin
      count_d = '0;
    end else if (iEn && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oExpired = iEn && (count_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one variable-latency memory port between fetch and data masters.
// Latency: strobes one cycle after request; valid/data one cycle after iMReady (min access 2 cycles).
// Backpressure: masters hold requests until their valid pulse; watchdog aborts a stalled slave.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAXD    = DEF_MAXD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iIReq,
  input  logic [AW-1:0] iIAddr,
  output logic [DW-1:0] oIReadData,
  output logic          oIValid,
  input  logic          iDRead,
  input  logic          iDWrite,
  input  logic [3:0]    iDByteEnable,
  input  logic [AW-1:0] iDAddr,
  input  logic [DW-1:0] iDWriteData,
  output logic [DW-1:0] oDReadData,
  output logic          oDValid,
  output logic          oMReadEnable,
  output logic          oMWriteEnable,
  output logic [3:0]    oMByteEnable,
  output logic [AW-1:0] oMAddress,
  output logic [DW-1:0] oMWriteData,
  input  logic [DW-1:0] iMReadData,
  input  logic          iMReady,
  output logic          oError,
  output logic          oBusy
);

  localparam logic [STARVE_W-1:0] MAXD_C = 3'(MAXD);

  logic [1:0]          state_q,   state_d;
  logic                m_rd_q,    m_rd_d;
  logic                m_wr_q,    m_wr_d;
  logic [3:0]          m_be_q,    m_be_d;
  logic [AW-1:0]       m_addr_q,  m_addr_d;
  logic [DW-1:0]       m_wdata_q, m_wdata_d;
  logic [DW-1:0]       i_rdata_q, i_rdata_d;
  logic [DW-1:0]       d_rdata_q, d_rdata_d;
  logic                i_vld_q,   i_vld_d;
  logic                d_vld_q,   d_vld_d;
  logic                err_q,     err_d;
  logic [STARVE_W-1:0] starve_q,  starve_d;

  logic arb;
  logic allow_i, allow_d;
  logic cand_i, cand_d;
  logic grant_i, grant_d;
  logic wd_expired;

  // Re-arbitration edges (idle or completion) restart the timeout window.
  bus_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iClr     (arb),
    .iEn      (state_q != IDLE),
    .oExpired (wd_expired)
  );

  // Completion/abort handling, then arbitration with the completing master excluded.
  always_comb begin
    state_d   = state_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_vld_d   = 1'b0;
    d_vld_d   = 1'b0;
    err_d     = 1'b0;
    starve_d  = starve_q;
    arb       = 1'b0;
    allow_i   = 1'b1;
    allow_d   = 1'b1;
    cand_i    = 1'b0;
    cand_d    = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;

    case (state_q)
      BUSY_I: begin
        if (iMReady) begin
          i_rdata_d = iMReadData;
          i_vld_d   = 1'b1;
          arb       = 1'b1;
          allow_i   = 1'b0;
        end else if (wd_expired) begin
          i_rdata_d = '0;
          i_vld_d   = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
          m_rd_d    = 1'b0;
          m_wr_d    = 1'b0;
        end
      end
      BUSY_D: begin
        if (iMReady) begin
          // Stores never return data; the load register keeps its last value.
          if (!m_wr_q) begin
            d_rdata_d = iMReadData;
          end
          d_vld_d = 1'b1;
          arb     = 1'b1;
          allow_d = 1'b0;
        end else if (wd_expired) begin
          d_rdata_d = '0;
          d_vld_d   = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
          m_rd_d    = 1'b0;
          m_wr_d    = 1'b0;
        end
      end
      default: arb = 1'b1;
    endcase

    if (arb) begin
      cand_i  = iIReq & allow_i;
      cand_d  = (iDRead | iDWrite) & allow_d;
      // Data wins unless the fetch has already been passed over MAXD times.
      grant_i = cand_i & (~cand_d | (starve_q == MAXD_C));
      grant_d = cand_d & ~grant_i;
      if (grant_i) begin
        state_d   = BUSY_I;
        m_rd_d    = 1'b1;
        m_wr_d    = 1'b0;
        m_be_d    = FETCH_BE;
        m_addr_d  = iIAddr;
        m_wdata_d = '0;
      end else if (grant_d) begin
        state_d   = BUSY_D;
        m_rd_d    = ~iDWrite;
        m_wr_d    = iDWrite;
        m_be_d    = iDByteEnable;
        m_addr_d  = iDAddr;
        m_wdata_d = iDWriteData;
      end else begin
        state_d = IDLE;
        m_rd_d  = 1'b0;
        m_wr_d  = 1'b0;
      end
    end

    if (grant_i || !iIReq) begin
      starve_d = '0;
    end else if (grant_d && (starve_q != '1)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State, latched access and returned data registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= IDLE;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_vld_q   <= 1'b0;
      d_vld_q   <= 1'b0;
      err_q     <= 1'b0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_vld_q   <= i_vld_d;
      d_vld_q   <= d_vld_d;
      err_q     <= err_d;
      starve_q  <= starve_d;
    end
  end

  assign oMReadEnable  = m_rd_q;
  assign oMWriteEnable = m_wr_q;
  assign oMByteEnable  = m_be_q;
  assign oMAddress     = m_addr_q;
  assign oMWriteData   = m_wdata_q;
  assign oIReadData    = i_rdata_q;
  assign oIValid       = i_vld_q;
  assign oDReadData    = d_rdata_q;
  assign oDValid       = d_vld_q;
  assign oError        = err_q;
  assign oBusy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed corner sequences and randomized masters/slave.
// Latency: inputs driven and outputs sampled on the falling edge of iCLK.
// Backpressure: masters hold requests until valid; slave model answers within 5 busy cycles.
module tb_mem_bus_arbiter;

  localparam int TO = 8;
  localparam int MD = 4;
  localparam logic [31:0] IADDR = 32'h0040_0000;
  localparam logic [31:0] DADDR = 32'h1001_0000;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iIReq;
  logic [31:0] iIAddr;
  logic [31:0] oIReadData;
  logic        oIValid;
  logic        iDRead, iDWrite;
  logic [3:0]  iDByteEnable;
  logic [31:0] iDAddr, iDWriteData;
  logic [31:0] oDReadData;
  logic        oDValid;
  logic        oMReadEnable, oMWriteEnable;
  logic [3:0]  oMByteEnable;
  logic [31:0] oMAddress, oMWriteData;
  logic [31:0] iMReadData;
  logic        iMReady;
  logic        oError, oBusy;

  mem_bus_arbiter #(.AW(32), .DW(32), .MAXD(MD), .TIMEOUT(TO)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIReq(iIReq), .iIAddr(iIAddr), .oIReadData(oIReadData), .oIValid(oIValid),
    .iDRead(iDRead), .iDWrite(iDWrite), .iDByteEnable(iDByteEnable), .iDAddr(iDAddr),
    .iDWriteData(iDWriteData), .oDReadData(oDReadData), .oDValid(oDValid),
    .oMReadEnable(oMReadEnable), .oMWriteEnable(oMWriteEnable), .oMByteEnable(oMByteEnable),
    .oMAddress(oMAddress), .oMWriteData(oMWriteData), .iMReadData(iMReadData),
    .iMReady(iMReady), .oError(oError), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iIReq = 0; iIAddr = 0; iDRead = 0; iDWrite = 0; iDByteEnable = 0;
    iDAddr = 0; iDWriteData = 0; iMReadData = 0; iMReady = 0;
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    idle_inputs();
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
  endtask

  // Slave read data as a pure function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  typedef struct {
    logic       ireq, drd, dwr;
    logic [3:0] dbe;
    logic       exp_rd, exp_wr;
    logic [3:0] exp_be;
    logic [31:0] exp_addr;
    logic       exp_busy, exp_ivld, exp_dvld;
  } vec_t;

  vec_t vt[7];
  int   kinds[$];
  int   exp_kinds[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  // Random-phase model state.
  logic        f_pend, d_pend, d_wr, s_act, issue_en;
  logic [31:0] f_addr, d_addr, d_wdata, s_addr, last_dr;
  logic [3:0]  d_be;
  int          s_wait, n_issued, n_done;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rv, vdata;
    int vcnt, vcyc, ecnt, ecyc, cnt;
    logic prev_busy, prev_rdy, fdone;
    int kind, typ;

    vt[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hF, IADDR, 1'b1, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h3, DADDR, 1'b1, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 4'hC, DADDR, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5, DADDR, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 4'hF, DADDR, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 4'h1, DADDR, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    iRST = 1'b1;
    idle_inputs();
    #1;
    chk("rst_mrd", oMReadEnable, 0);
    chk("rst_mwr", oMWriteEnable, 0);
    chk("rst_mbe", oMByteEnable, 0);
    chk("rst_maddr", oMAddress, 0);
    chk("rst_mwdata", oMWriteData, 0);
    chk("rst_valids", {oIValid, oDValid, oError, oBusy}, 0);
    chk("rst_irdata", oIReadData, 0);
    chk("rst_drdata", oDReadData, 0);
    do_reset();

    // Vector table: grant decision from IDLE, then a one-cycle completion.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      rv = 32'hA500_0000 + i;
      iIReq = vt[i].ireq; iIAddr = IADDR;
      iDRead = vt[i].drd; iDWrite = vt[i].dwr; iDByteEnable = vt[i].dbe;
      iDAddr = DADDR; iDWriteData = 32'h0BAD_F000 + i;
      @(negedge iCLK);
      chk($sformatf("v%0d_rd", i), oMReadEnable, vt[i].exp_rd);
      chk($sformatf("v%0d_wr", i), oMWriteEnable, vt[i].exp_wr);
      chk($sformatf("v%0d_be", i), oMByteEnable, vt[i].exp_be);
      chk($sformatf("v%0d_addr", i), oMAddress, vt[i].exp_addr);
      chk($sformatf("v%0d_busy", i), oBusy, vt[i].exp_busy);
      if (vt[i].exp_wr) chk($sformatf("v%0d_wdata", i), oMWriteData, 32'h0BAD_F000 + i);
      iMReady = 1'b1; iMReadData = rv;
      @(negedge iCLK);
      iMReady = 1'b0;
      chk($sformatf("v%0d_ivld", i), oIValid, vt[i].exp_ivld);
      chk($sformatf("v%0d_dvld", i), oDValid, vt[i].exp_dvld);
      if (vt[i].exp_ivld) chk($sformatf("v%0d_irdata", i), oIReadData, rv);
      if (vt[i].exp_dvld) chk($sformatf("v%0d_drdata", i), oDReadData, vt[i].exp_wr ? 32'h0 : rv);
    end

    // Fetch only, slave answers in the third busy cycle.
    do_reset();
    iIReq = 1'b1; iIAddr = IADDR;
    vcnt = 0; vcyc = 0; vdata = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge iCLK);
      if (k == 1) chk("fetch_be", oMByteEnable, 4'hF);
      if (oIValid) begin
        vcnt++; vcyc = k; vdata = oIReadData; iIReq = 1'b0;
      end
      iMReady = (k == 3); iMReadData = 32'h0000_0013;
    end
    chk("fetch_vld_count", vcnt, 1);
    chk("fetch_vld_cycle", vcyc, 4);
    chk("fetch_data", vdata, 32'h0000_0013);

    // Simultaneous fetch and load: load first, fetch starts with no idle cycle.
    do_reset();
    iIReq = 1'b1; iIAddr = IADDR; iDRead = 1'b1; iDAddr = DADDR; iDByteEnable = 4'h3;
    @(negedge iCLK);
    chk("both_first_addr", oMAddress, DADDR);
    iMReady = 1'b1; iMReadData = 32'h1111_2222;
    @(negedge iCLK);
    chk("both_dvld", oDValid, 1);
    chk("both_ddata", oDReadData, 32'h1111_2222);
    chk("both_no_bubble", oBusy, 1);
    chk("both_second_addr", oMAddress, IADDR);
    chk("both_second_be", oMByteEnable, 4'hF);
    iDRead = 1'b0; iMReadData = 32'h3333_4444;
    @(negedge iCLK);
    iMReady = 1'b0; iIReq = 1'b0;
    chk("both_ivld", oIValid, 1);
    chk("both_idata", oIReadData, 32'h3333_4444);
    @(negedge iCLK);
    chk("both_idle", oBusy, 0);

    // Store: latched write data stays put while the master changes its inputs.
    iDWrite = 1'b1; iDByteEnable = 4'b0011; iDWriteData = 32'hDEAD_BEEF; iDAddr = DADDR + 4;
    for (int k = 1; k <= 4; k++) begin
      @(negedge iCLK);
      if (k <= 3) begin
        chk($sformatf("store_wdata_c%0d", k), oMWriteData, 32'hDEAD_BEEF);
        chk($sformatf("store_addr_c%0d", k), oMAddress, DADDR + 4);
        chk($sformatf("store_be_c%0d", k), oMByteEnable, 4'b0011);
      end
      iDWriteData = 32'h1234_5678 + k; iDAddr = 32'h0; iDByteEnable = 4'hF;
      iMReady = (k == 3);
      if (k == 4) begin
        chk("store_dvld", oDValid, 1);
        chk("store_rdata_kept", oDReadData, 32'h1111_2222);
        iDWrite = 1'b0;
      end
    end

    // Timeout: slave never answers.
    iMReady = 1'b0;
    iDRead = 1'b1; iDAddr = DADDR; iDByteEnable = 4'hF;
    ecnt = 0; ecyc = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge iCLK);
      if (oError) begin
        ecnt++; ecyc = k;
        chk("to_dvld_with_err", oDValid, 1);
        chk("to_rdata_zero", oDReadData, 0);
        iDRead = 1'b0;
      end
    end
    chk("to_err_count", ecnt, 1);
    chk("to_edges_after_grant", ecyc - 1, TO);

    // Slave answers in the same cycle the watchdog would fire: normal completion.
    iDRead = 1'b1; ecnt = 0; vcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge iCLK);
      if (oError) ecnt++;
      if (oDValid) begin
        vcnt++;
        chk("to_edge_data", oDReadData, 32'h5555_AAAA);
        iDRead = 1'b0;
      end
      iMReady = (k == TO); iMReadData = 32'h5555_AAAA;
    end
    chk("to_edge_no_err", ecnt, 0);
    chk("to_edge_vld_count", vcnt, 1);

    // Reset in BUSY_D: outputs clear at once, no completion afterwards.
    iMReady = 1'b0; iDRead = 1'b1; iDAddr = DADDR;
    repeat (2) @(negedge iCLK);
    chk("mid_rst_busy_before", oBusy, 1);
    #2 iRST = 1'b1;
    #1;
    chk("mid_rst_outs", {oBusy, oMReadEnable, oMWriteEnable, oDValid, oIValid, oError}, 0);
    chk("mid_rst_maddr", oMAddress, 0);
    chk("mid_rst_drdata", oDReadData, 0);
    @(negedge iCLK);
    iRST = 1'b0; iDRead = 1'b0; iMReady = 1'b1; iMReadData = 32'hFFFF_0000;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge iCLK);
      iMReady = 1'b0;
      if (oDValid || oIValid || oBusy) cnt++;
    end
    chk("mid_rst_no_vld", cnt, 0);

    // Starvation: stores time out repeatedly while a fetch waits.
    do_reset();
    iDWrite = 1'b1; iDAddr = DADDR; iDByteEnable = 4'hF; iIReq = 1'b1; iIAddr = IADDR;
    kinds.delete();
    prev_busy = 1'b0; prev_rdy = 1'b0; fdone = 1'b0;
    for (int c = 0; c < 300 && kinds.size() < 10; c++) begin
      @(negedge iCLK);
      iMReady = 1'b0;
      if (oBusy && (!prev_busy || prev_rdy)) begin
        kind = oMWriteEnable ? 1 : ((oMReadEnable && oMAddress == IADDR) ? 0 : 2);
        kinds.push_back(kind);
        if (kind == 0 && !fdone) begin
          iMReady = 1'b1; iMReadData = 32'h0000_0001; fdone = 1'b1;
        end
      end
      prev_busy = oBusy; prev_rdy = iMReady;
    end
    chk("starve_grants_seen", kinds.size(), 10);
    for (int i = 0; i < kinds.size(); i++)
      chk($sformatf("starve_grant%0d", i), kinds[i], exp_kinds[i]);

    // Randomized masters and slave against the protocol-level model.
    do_reset();
    f_pend = 0; d_pend = 0; d_wr = 0; s_act = 0; s_wait = 0; last_dr = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; s_addr = 0;
    n_issued = 0; n_done = 0; issue_en = 1;
    for (int c = 0; c < 3300; c++) begin
      @(negedge iCLK);
      if (c == 3000) issue_en = 0;
      if (!issue_en && !f_pend && !d_pend) break;
      chk("rnd_no_error", oError, 0);
      if (oIValid) begin
        chk("rnd_ivld_owner", f_pend, 1);
        chk("rnd_idata", oIReadData, mem_f(f_addr));
        f_pend = 0; n_done++;
      end
      if (oDValid) begin
        chk("rnd_dvld_owner", d_pend, 1);
        if (!d_wr) last_dr = mem_f(d_addr);
        chk("rnd_ddata", oDReadData, last_dr);
        d_pend = 0; n_done++;
      end
      if (!oBusy) chk("rnd_idle_strobes", {oMReadEnable, oMWriteEnable}, 0);
      if (oBusy && !s_act) begin
        s_act = 1; s_addr = oMAddress; s_wait = $urandom_range(0, 4);
        if (oMWriteEnable) begin
          chk("rnd_wr_owner", d_pend && d_wr, 1);
          chk("rnd_wr_addr", oMAddress, d_addr);
          chk("rnd_wr_be", oMByteEnable, d_be);
          chk("rnd_wr_data", oMWriteData, d_wdata);
        end else if (oMAddress[31:24] == 8'h00) begin
          chk("rnd_f_owner", f_pend && oMReadEnable, 1);
          chk("rnd_f_addr", oMAddress, f_addr);
          chk("rnd_f_be", oMByteEnable, 4'hF);
        end else begin
          chk("rnd_rd_owner", d_pend && !d_wr && oMReadEnable, 1);
          chk("rnd_rd_addr", oMAddress, d_addr);
          chk("rnd_rd_be", oMByteEnable, d_be);
        end
      end else if (oBusy) begin
        chk("rnd_addr_stable", oMAddress, s_addr);
      end
      iMReady = 1'b0;
      if (s_act) begin
        if (s_wait == 0) begin
          iMReady = 1'b1; iMReadData = mem_f(s_addr); s_act = 0;
        end else begin
          s_wait--;
        end
      end else if (!oBusy && $urandom_range(0, 3) == 0) begin
        iMReady = 1'b1; iMReadData = $urandom;
      end
      if (issue_en && !f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1; n_issued++;
        f_addr = {16'h0040, 14'($urandom), 2'b00};
      end
      if (issue_en && !d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; n_issued++;
        typ = $urandom_range(0, 2);
        d_wr = (typ != 0);
        d_be = 4'($urandom);
        d_addr = {16'h1001, 14'($urandom), 2'b00};
        d_wdata = $urandom;
        iDRead = (typ != 1); iDWrite = d_wr;
      end
      if (!d_pend) begin
        iDRead = 1'b0; iDWrite = 1'b0;
      end
      iIReq = f_pend; iIAddr = f_addr;
      iDAddr = d_addr; iDByteEnable = d_be; iDWriteData = d_wdata;
    end
    chk("rnd_drained", {f_pend, d_pend}, 0);
    chk("rnd_all_done", n_done, n_issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
